// File: rtl/prbs9_pkg.sv
// Shared PRBS9 definitions for the BER loopback generator and checker:
// polynomial length, feedback taps (x^9 + x^5 + 1), the common seed and the
// checker state encoding.
package prbs9_pkg;

  localparam int PRBS_LEN = 9;
  localparam int TAP_HI   = 8;
  localparam int TAP_LO   = 4;

  localparam logic [PRBS_LEN-1:0] PRBS_SEED = 9'h1FF;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } chk_state_e;

endpackage

// File: rtl/prbs9_lfsr_step.sv
// One PRBS9 LFSR step (shift-left, new bit into bit 0). The prediction is the
// feedback bit; the next state takes either the received bit (self-sync) or
// the prediction (free-run).
module prbs9_lfsr_step
  import prbs9_pkg::*;
(
  input  logic [PRBS_LEN-1:0] state,
  input  logic                din,
  input  logic                self_sync,
  output logic                pred,
  output logic [PRBS_LEN-1:0] nxt
);

  // Feedback prediction and next register contents
  always_comb begin
    pred = state[TAP_HI] ^ state[TAP_LO];
    nxt  = {state[PRBS_LEN-2:0], (self_sync ? din : pred)};
  end

endmodule

// File: rtl/prbs9_chk.sv
// Self-synchronising PRBS9 checker. Seeds a local LFSR from the received
// stream, hunts for LOCK_THR consecutive correct predictions, then free-runs
// and counts checked bits and errors. Too many errors inside one WIN-bit
// window drops lock and restarts seeding.
// Build option: define PRBS9_CHK_SATURATE_EN to make o_bit_cnt / o_err_cnt
// saturate at all-ones instead of wrapping.
module prbs9_chk
  import prbs9_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int LOCK_THR = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int WIN_W  = $clog2(WIN);
  localparam int WERR_W = $clog2(WIN + 1);

  localparam logic [7:0]        MATCH_LAST = 8'(LOCK_THR - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN - 1);
  localparam logic [WERR_W-1:0] LOSS_LAST  = WERR_W'(LOSS_THR - 1);

  chk_state_e          state, state_nxt;
  logic [PRBS_LEN-1:0] lfsr, lfsr_nxt, step_nxt;
  logic [3:0]          fill, fill_nxt;
  logic [7:0]          match, match_nxt;
  logic [WIN_W-1:0]    win, win_nxt;
  logic [WERR_W-1:0]   werr, werr_nxt;
  logic [CNT_W-1:0]    bit_cnt_nxt, err_cnt_nxt;
  logic                accept, self_sync, pred, miss, lock_nxt, err_nxt;

  // Counter increment: wrap by default, optionally stick at all-ones
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef PRBS9_CHK_SATURATE_EN
    cnt_inc = (&v) ? v : v + CNT_W'(1);
`else
    cnt_inc = v + CNT_W'(1);
`endif
  endfunction

  assign accept    = i_enable & i_valid;
  assign self_sync = (state != LOCK);
  assign miss      = i_bit ^ pred;

  prbs9_lfsr_step u_step (
    .state     (lfsr),
    .din       (i_bit),
    .self_sync (self_sync),
    .pred      (pred),
    .nxt       (step_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEED;
    else      state <= state_nxt;
  end

  // Next-state decode; only accepted bits move the FSM
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        // An all-zero seed would predict zeros forever, so it is refused
        SEED:    if (fill == 4'd8) state_nxt = (step_nxt == '0) ? SEED : HUNT;
        HUNT:    if (!miss && match == MATCH_LAST) state_nxt = LOCK;
        LOCK:    if (miss && werr == LOSS_LAST) state_nxt = SEED;
        default: state_nxt = SEED;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    lfsr_nxt    = lfsr;
    fill_nxt    = fill;
    match_nxt   = match;
    win_nxt     = win;
    werr_nxt    = werr;
    bit_cnt_nxt = o_bit_cnt;
    err_cnt_nxt = o_err_cnt;
    err_nxt     = 1'b0;
    lock_nxt    = (state_nxt == LOCK);
    if (accept) begin
      lfsr_nxt = step_nxt;
      case (state)
        SEED: begin
          fill_nxt  = (fill == 4'd8) ? 4'd0 : fill + 4'd1;
          match_nxt = 8'd0;
        end
        HUNT: begin
          match_nxt = miss ? 8'd0 : match + 8'd1;
          win_nxt   = '0;
          werr_nxt  = '0;
        end
        LOCK: begin
          bit_cnt_nxt = cnt_inc(o_bit_cnt);
          if (miss) begin
            err_cnt_nxt = cnt_inc(o_err_cnt);
            err_nxt     = 1'b1;
          end
          if (state_nxt == SEED) begin
            fill_nxt = 4'd0;
            win_nxt  = '0;
            werr_nxt = '0;
          end else if (win == WIN_LAST) begin
            win_nxt  = '0;
            werr_nxt = '0;
          end else begin
            win_nxt  = win + WIN_W'(1);
            werr_nxt = werr + WERR_W'(miss);
          end
        end
        default: fill_nxt = 4'd0;
      endcase
    end
    // Clear beats any increment landing on the same edge
    if (i_clear) begin
      bit_cnt_nxt = '0;
      err_cnt_nxt = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= '0;
      fill      <= 4'd0;
      match     <= 8'd0;
      win       <= '0;
      werr      <= '0;
      o_lock    <= 1'b0;
      o_err     <= 1'b0;
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else begin
      lfsr      <= lfsr_nxt;
      fill      <= fill_nxt;
      match     <= match_nxt;
      win       <= win_nxt;
      werr      <= werr_nxt;
      o_lock    <= lock_nxt;
      o_err     <= err_nxt;
      o_bit_cnt <= bit_cnt_nxt;
      o_err_cnt <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs9_chk.sv
// Directed bench for prbs9_chk: acquisition, error counting, loss/relock,
// HUNT restart, clear priority, enable freeze, async reset, zero-seed refusal
// and counter wrap/saturation on a narrow-counter instance.
module tb_prbs9_chk;
  import prbs9_pkg::*;

  logic clk = 1'b0;
  logic rst, i_enable, i_valid, i_bit, i_clear;
  logic o_lock, o_err;
  logic [31:0] o_bit_cnt, o_err_cnt;
  logic n_lock, n_err;
  logic [3:0] n_bit_cnt, n_err_cnt;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [PRBS_LEN-1:0] gen;

  prbs9_chk dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .i_clear(i_clear), .o_lock(o_lock), .o_err(o_err),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
  );

  prbs9_chk #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .i_clear(i_clear), .o_lock(n_lock), .o_err(n_err),
    .o_bit_cnt(n_bit_cnt), .o_err_cnt(n_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Generator model: emits feedback bit, shifts it in
  task automatic gen_next(output logic b);
    b = gen[8] ^ gen[4];
    gen = {gen[7:0], b};
  endtask

  task automatic send_bit(input logic b);
    i_enable = 1'b1;
    i_valid  = 1'b1;
    i_bit    = b;
    @(posedge clk);
    #1;
    if (o_err) err_pulses++;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int k = 0; k < n; k++) begin
      gen_next(b);
      send_bit(b);
    end
  endtask

  task automatic send_bad();
    logic b;
    gen_next(b);
    send_bit(~b);
  endtask

  logic bb;

  initial begin
    rst = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_bit = 1'b0; i_clear = 1'b0;
    gen = PRBS_SEED;
    repeat (2) @(posedge clk);
    #1;
    check("rst_lock", o_lock, 0);
    check("rst_err", o_err, 0);
    check("rst_bitcnt", o_bit_cnt, 0);
    check("rst_errcnt", o_err_cnt, 0);
    rst = 1'b1;

    // Acquisition: 9 seed bits + 16 matches
    send_clean(24);
    check("acq_24_nolock", o_lock, 0);
    send_clean(1);
    check("acq_25_lock", o_lock, 1);
    check("acq_bitcnt0", o_bit_cnt, 0);

    send_clean(20);
    check("bitcnt_20", o_bit_cnt, 20);
`ifdef PRBS9_CHK_SATURATE_EN
    check("narrow_sat", n_bit_cnt, 15);
`else
    check("narrow_wrap", n_bit_cnt, 4);
`endif
    send_clean(980);
    check("clean_bitcnt", o_bit_cnt, 1000);
    check("clean_errcnt", o_err_cnt, 0);
    check("clean_pulses", err_pulses, 0);

    // One inverted bit per 100: never two in a 64-bit window
    for (int k = 0; k < 10; k++) begin
      send_clean(99);
      send_bad();
    end
    check("sparse_errcnt", o_err_cnt, 10);
    check("sparse_bitcnt", o_bit_cnt, 2000);
    check("sparse_pulses", err_pulses, 10);
    check("sparse_lock", o_lock, 1);

    // Clear on an errored accepted bit (window position 16)
    i_clear = 1'b1;
    send_bad();
    i_clear = 1'b0;
    check("clr_bitcnt", o_bit_cnt, 0);
    check("clr_errcnt", o_err_cnt, 0);
    check("clr_lock", o_lock, 1);
    check("clr_err_pulse", o_err, 1);
    send_clean(1);
    check("err_single_cycle", o_err, 0);
    check("clr_not_sticky", o_bit_cnt, 1);

    // Window position is now 18; 46 clean bits reach a fresh window
    send_clean(46);
    for (int k = 0; k < 7; k++) send_bad();
    check("loss_7_still_lock", o_lock, 1);
    send_bad();
    check("loss_8_unlock", o_lock, 0);
    check("loss_bitcnt", o_bit_cnt, 55);
    check("loss_errcnt", o_err_cnt, 8);

    send_clean(24);
    check("relock_24", o_lock, 0);
    send_clean(1);
    check("relock_25", o_lock, 1);
    check("relock_bitcnt", o_bit_cnt, 55);

    // Asynchronous reset mid-operation, away from a clock edge
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_lock", o_lock, 0);
    check("async_rst_bitcnt", o_bit_cnt, 0);
    #1;
    rst = 1'b1;

    // HUNT error at match count 10. The bad bit sits in the LFSR and hits
    // tap 4 five bits later and tap 8 nine bits later, so lock lands on the
    // 25th clean bit after it.
    send_clean(9 + 10);
    send_bad();
    send_clean(16);
    check("hunt_restart_16", o_lock, 0);
    send_clean(8);
    check("hunt_24", o_lock, 0);
    send_clean(1);
    check("hunt_lock_25", o_lock, 1);

    // Enable low freezes everything, even with garbage on i_bit
    send_clean(10);
    check("pre_freeze_bitcnt", o_bit_cnt, 10);
    for (int k = 0; k < 5; k++) begin
      i_enable = 1'b0;
      i_valid  = 1'b1;
      i_bit    = k[0];
      @(posedge clk);
      #1;
      if (o_err) err_pulses++;
    end
    check("freeze_bitcnt", o_bit_cnt, 10);
    check("freeze_lock", o_lock, 1);
    send_clean(10);
    check("resume_bitcnt", o_bit_cnt, 20);
    check("resume_errcnt", o_err_cnt, 0);

    // All-zero stream never leaves seeding
    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < 40; k++) send_bit(1'b0);
    check("zero_seed_nolock", o_lock, 0);
    check("zero_seed_bitcnt", o_bit_cnt, 0);

    i_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
